// File: rtl/mips_defs.sv
// Shared definitions for the MEM stage: opcodes, exception codes, FSM states
// and small decode helpers.
package mips_defs;

  localparam logic [5:0] LB  = 6'h20;
  localparam logic [5:0] LH  = 6'h21;
  localparam logic [5:0] LW  = 6'h23;
  localparam logic [5:0] LBU = 6'h24;
  localparam logic [5:0] LHU = 6'h25;
  localparam logic [5:0] SB  = 6'h28;
  localparam logic [5:0] SH  = 6'h29;
  localparam logic [5:0] SW  = 6'h2B;

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;

  localparam logic [31:0] NOP = 32'h0000_0000;

  typedef enum logic {IDLE, BUSY} state_e;

  function automatic logic is_load(input logic [5:0] op);
    return (op == LB) || (op == LH) || (op == LW) || (op == LBU) || (op == LHU);
  endfunction

  function automatic logic is_store(input logic [5:0] op);
    return (op == SB) || (op == SH) || (op == SW);
  endfunction

  // Alignment fault for a given access opcode and low address bits.
  function automatic logic is_misaligned(input logic [5:0] op, input logic [1:0] lo);
    logic r;
    r = 1'b0;
    if ((op == LW) || (op == SW)) r = (lo != 2'b00);
    else if ((op == LH) || (op == LHU) || (op == SH)) r = lo[0];
    return r;
  endfunction

endpackage

// File: rtl/dm_ext.sv
// Load data extender: picks the addressed byte/half out of a little-endian
// bus word and sign/zero-extends it according to the load opcode.
// Ports:
//   addr_lo : byte offset within the word
//   funct   : load opcode (non-load opcodes give 0)
//   rdata   : raw bus read word
//   result  : extended load result
module dm_ext
  import mips_defs::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [5:0]  funct,
  input  logic [31:0] rdata,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[7:0];
    case (addr_lo)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    result = 32'h0;
    case (funct)
      LB:      result = {{24{byte_sel[7]}}, byte_sel};
      LBU:     result = {24'h0, byte_sel};
      LH:      result = {{16{half_sel[15]}}, half_sel};
      LHU:     result = {16'h0, half_sel};
      LW:      result = rdata;
      default: result = 32'h0;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: decodes loads/stores, checks address faults, runs a req/ack
// data-bus handshake with variable latency (stalling the pipe meanwhile),
// extends load data and holds the MEM/WB pipeline register.
// Ports:
//   clk, reset            : clock, async active-low reset
//   *_MEM inputs          : instruction, address/ALU result, store data, PC+8, CP0 data
//   flush_MEM             : kill the MEM instruction
//   mem_req..mem_wdata    : bus request side
//   mem_rdata, mem_ack    : bus response side
//   stall_MEM             : freeze IF..MEM
//   exc_MEM, exc_code_MEM : address exception (combinational)
//   *_WB outputs          : MEM/WB register
module mem_access_stage
  import mips_defs::*;
#(
  parameter logic [31:0] DM_BASE  = 32'h0000_0000,
  parameter logic [31:0] DM_LIMIT = 32'h0000_2FFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instr_MEM,
  input  logic [31:0] ALUout_MEM,
  input  logic [31:0] WD_MEM,
  input  logic [31:0] PC8_MEM,
  input  logic [31:0] CP0_RD_MEM,
  input  logic        flush_MEM,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        stall_MEM,
  output logic        exc_MEM,
  output logic [4:0]  exc_code_MEM,
  output logic [31:0] Instr_WB,
  output logic [31:0] ALUout_WB,
  output logic [31:0] DM_RD_WB,
  output logic [31:0] PC8_WB,
  output logic [31:0] CP0_RD_WB
);

  logic [5:0] op;
  logic       ld, st, acc, out_of_range, exc_raw, go;
  logic [3:0] live_be;
  logic [31:0] live_wdata;

  state_e      state_q, state_d;
  logic        flush_pend_q, flush_pend_d;
  logic        latch;
  logic [31:0] addr_q, wdata_q;
  logic        we_q;
  logic [3:0]  be_q;
  logic [5:0]  funct_q;
  logic [1:0]  lo_q;

  logic [5:0]  ext_funct;
  logic [1:0]  ext_lo;
  logic [31:0] ext_data;
  logic        bubble;

  assign op = Instr_MEM[31:26];

  always_comb begin
    ld  = is_load(op);
    st  = is_store(op);
    acc = ld | st;
    // Offset compare keeps the range check free of constant comparisons.
    out_of_range = (ALUout_MEM - DM_BASE) > (DM_LIMIT - DM_BASE);
    exc_raw      = acc & (is_misaligned(op, ALUout_MEM[1:0]) | out_of_range);
    exc_MEM      = exc_raw & ~flush_MEM;
    exc_code_MEM = exc_MEM ? (ld ? EXC_ADEL : EXC_ADES) : EXC_NONE;
    // Reset term makes mem_req drop as soon as reset asserts.
    go = acc & ~exc_raw & ~flush_MEM & reset;
  end

  always_comb begin
    live_be    = 4'b0000;
    live_wdata = 32'h0;
    case (op)
      SW: begin
        live_be    = 4'b1111;
        live_wdata = WD_MEM;
      end
      SH: begin
        live_be    = ALUout_MEM[1] ? 4'b1100 : 4'b0011;
        live_wdata = {2{WD_MEM[15:0]}};
      end
      SB: begin
        live_be    = 4'b0001 << ALUout_MEM[1:0];
        live_wdata = {4{WD_MEM[7:0]}};
      end
      default: begin
        if (ld) live_be = 4'b1111;
      end
    endcase
  end

  always_comb begin
    state_d      = state_q;
    flush_pend_d = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_be       = 4'b0000;
    mem_addr     = {ALUout_MEM[31:2], 2'b00};
    mem_wdata    = 32'h0;
    stall_MEM    = 1'b0;
    latch        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (go) begin
          mem_req   = 1'b1;
          mem_we    = st;
          mem_be    = live_be;
          mem_wdata = live_wdata;
          latch     = 1'b1;
          stall_MEM = ~mem_ack;
          if (!mem_ack) state_d = BUSY;
        end
      end
      BUSY: begin
        mem_req      = 1'b1;
        mem_addr     = addr_q;
        mem_we       = we_q;
        mem_be       = be_q;
        mem_wdata    = wdata_q;
        stall_MEM    = ~mem_ack;
        flush_pend_d = flush_pend_q | flush_MEM;
        if (mem_ack) begin
          state_d      = IDLE;
          flush_pend_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      flush_pend_q <= 1'b0;
      addr_q       <= 32'h0;
      wdata_q      <= 32'h0;
      we_q         <= 1'b0;
      be_q         <= 4'b0000;
      funct_q      <= 6'h0;
      lo_q         <= 2'b00;
    end else begin
      state_q      <= state_d;
      flush_pend_q <= flush_pend_d;
      if (latch) begin
        addr_q  <= {ALUout_MEM[31:2], 2'b00};
        wdata_q <= live_wdata;
        we_q    <= st;
        be_q    <= live_be;
        funct_q <= op;
        lo_q    <= ALUout_MEM[1:0];
      end
    end
  end

  // A zero-wait access completes before the hold registers are written, so
  // the extender uses live decode in IDLE and held decode in BUSY.
  assign ext_funct = (state_q == BUSY) ? funct_q : op;
  assign ext_lo    = (state_q == BUSY) ? lo_q : ALUout_MEM[1:0];

  dm_ext u_dm_ext (
    .addr_lo (ext_lo),
    .funct   (ext_funct),
    .rdata   (mem_rdata),
    .result  (ext_data)
  );

  assign bubble = flush_MEM | exc_MEM | flush_pend_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Instr_WB  <= NOP;
      ALUout_WB <= 32'h0;
      DM_RD_WB  <= 32'h0;
      PC8_WB    <= 32'h0;
      CP0_RD_WB <= 32'h0;
    end else if (!stall_MEM) begin
      if (bubble) begin
        Instr_WB  <= NOP;
        ALUout_WB <= 32'h0;
        DM_RD_WB  <= 32'h0;
        PC8_WB    <= 32'h0;
        CP0_RD_WB <= 32'h0;
      end else begin
        Instr_WB  <= Instr_MEM;
        ALUout_WB <= ALUout_MEM;
        DM_RD_WB  <= ext_data;
        PC8_WB    <= PC8_MEM;
        CP0_RD_WB <= CP0_RD_MEM;
      end
    end
  end

endmodule
